vote_session_ctrl: RTL and testbench

Sequencer for one five-voter ballot session in front of the `Vote_machine` majority datapath. It collects one one-hot ballot from each of voters A–E, locks each voter after the first valid ballot, and closes the session when all five have voted or a timeout expires. It then presents the ballots to `Vote_machine`, registers its `R` output as the session result, and holds the result until the next session. `Vote_machine` is instantiated beside this block by the parent; this block only drives its A–E inputs and samples its `R`.

---
 rtl/vote_pkg.sv | 29 ++
 rtl/ballot_slot.sv | 51 +++++
 rtl/vote_session_ctrl.sv | 151 +++++++++++++++
 tb/tb_vote_session_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/vote_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vote_pkg
//  Description : Shared types, ballot encodings and legality check for the
//                five-voter ballot session controller.
//  Revision    : 1.0  initial release
// ============================================================================
package vote_pkg;

    localparam int N_VOTERS = 5;

    localparam logic [2:0] CH0     = 3'b001;
    localparam logic [2:0] CH1     = 3'b010;
    localparam logic [2:0] CH2     = 3'b100;
    localparam logic [2:0] ABSTAIN = 3'b000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SETTLE  = 2'd2,
        RESULT  = 2'd3
    } state_t;

    function automatic logic is_legal(input logic [2:0] choice);
        return (choice == CH0) || (choice == CH1) || (choice == CH2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ballot_slot.sv
`default_nettype none
// ============================================================================
//  Module      : ballot_slot
//  Description : One voter's ballot register and lock bit with accept/reject
//                decision; only the first legal ballot of a session sticks.
//  Revision    : 1.0  initial release
// ============================================================================
module ballot_slot
    import vote_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clear,
    input  logic       i_enable,
    input  logic       i_vote_valid,
    input  logic [2:0] i_vote_choice,
    output logic [2:0] o_ballot,
    output logic       o_voted,
    output logic       o_voted_next,
    output logic       o_reject
);

    logic [2:0] r_ballot;
    logic       r_voted;
    logic       w_legal;
    logic       w_accept;

    assign w_legal      = is_legal(i_vote_choice);
    assign w_accept     = i_enable && i_vote_valid && !r_voted && w_legal;
    assign o_reject     = i_enable && i_vote_valid && (r_voted || !w_legal);
    // Look-ahead lock bit lets the parent close the session on the last accept.
    assign o_voted_next = i_clear ? 1'b0 : (r_voted || w_accept);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ballot <= ABSTAIN;
            r_voted  <= 1'b0;
        end else if (i_clear) begin
            r_ballot <= ABSTAIN;
            r_voted  <= 1'b0;
        end else if (w_accept) begin
            r_ballot <= i_vote_choice;
            r_voted  <= 1'b1;
        end
    end

    assign o_ballot = r_ballot;
    assign o_voted  = r_voted;

endmodule
`default_nettype wire

// File: rtl/vote_session_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : vote_session_ctrl
//  Description : Sequences one five-voter ballot session, presents the
//                ballots to the majority datapath and registers its result.
//  Revision    : 1.0  initial release
// ============================================================================
module vote_session_ctrl
    import vote_pkg::*;
#(
    parameter int TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [4:0]  vote_valid,
    input  logic [14:0] vote_choice,
    input  logic [2:0]  vm_r,
    output logic [2:0]  ballot_a,
    output logic [2:0]  ballot_b,
    output logic [2:0]  ballot_c,
    output logic [2:0]  ballot_d,
    output logic [2:0]  ballot_e,
    output logic        busy,
    output logic [4:0]  voted,
    output logic [2:0]  turnout,
    output logic        reject,
    output logic        done,
    output logic [2:0]  result,
    output logic        timed_out
);

    localparam int                   c_timer_w    = $clog2(TIMEOUT);
    localparam logic [c_timer_w-1:0] c_timer_last = c_timer_w'(TIMEOUT - 1);

    state_t                   r_state;
    state_t                   w_state_next;
    logic [c_timer_w-1:0]     r_timer;
    logic                     r_timed_out;
    logic                     r_done;
    logic                     r_reject;
    logic [2:0]               r_result;
    logic [2:0]               r_turnout;

    logic                     w_clear;
    logic                     w_enable;
    logic                     w_all_voted;
    logic                     w_timer_hit;
    logic                     w_busy;
    logic                     w_show;
    logic [2:0]               w_count_next;
    logic [N_VOTERS-1:0]      w_voted;
    logic [N_VOTERS-1:0]      w_voted_next;
    logic [N_VOTERS-1:0]      w_slot_reject;
    logic [N_VOTERS-1:0][2:0] w_ballot;

    assign w_clear     = start && ((r_state == IDLE) || (r_state == RESULT));
    assign w_enable    = (r_state == COLLECT);
    assign w_all_voted = &w_voted_next;
    assign w_timer_hit = (r_timer == c_timer_last);

    generate
        for (genvar gi = 0; gi < N_VOTERS; gi++) begin : g_slot
            ballot_slot u_slot (
                .clk          (clk),
                .rst_n        (rst_n),
                .i_clear      (w_clear),
                .i_enable     (w_enable),
                .i_vote_valid (vote_valid[gi]),
                .i_vote_choice(vote_choice[3*gi +: 3]),
                .o_ballot     (w_ballot[gi]),
                .o_voted      (w_voted[gi]),
                .o_voted_next (w_voted_next[gi]),
                .o_reject     (w_slot_reject[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = COLLECT;
            COLLECT: if (w_all_voted || w_timer_hit) w_state_next = SETTLE;
            SETTLE:  w_state_next = RESULT;
            RESULT:  if (start) w_state_next = COLLECT;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        w_show = 1'b0;
        case (r_state)
            COLLECT: w_busy = 1'b1;
            SETTLE:  begin w_busy = 1'b1; w_show = 1'b1; end
            RESULT:  w_show = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        w_count_next = 3'd0;
        for (int i = 0; i < N_VOTERS; i++) begin
            w_count_next = w_count_next + {2'b00, w_voted_next[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_timer     <= '0;
            r_timed_out <= 1'b0;
            r_done      <= 1'b0;
            r_reject    <= 1'b0;
            r_result    <= ABSTAIN;
            r_turnout   <= 3'd0;
        end else begin
            r_done    <= (r_state == SETTLE);
            r_reject  <= |w_slot_reject;
            r_turnout <= w_count_next;
            if (w_clear) begin
                r_timer     <= '0;
                r_timed_out <= 1'b0;
            end else if (w_enable) begin
                r_timer <= r_timer + 1'b1;
                // A full turnout on the timeout edge is a normal close.
                if (w_timer_hit && !w_all_voted) r_timed_out <= 1'b1;
            end
            if (r_state == SETTLE) r_result <= vm_r;
        end
    end

    assign ballot_a  = w_show ? w_ballot[0] : ABSTAIN;
    assign ballot_b  = w_show ? w_ballot[1] : ABSTAIN;
    assign ballot_c  = w_show ? w_ballot[2] : ABSTAIN;
    assign ballot_d  = w_show ? w_ballot[3] : ABSTAIN;
    assign ballot_e  = w_show ? w_ballot[4] : ABSTAIN;
    assign busy      = w_busy;
    assign voted     = w_voted;
    assign turnout   = r_turnout;
    assign reject    = r_reject;
    assign done      = r_done;
    assign result    = r_result;
    assign timed_out = r_timed_out;

endmodule
`default_nettype wire

// File: tb/tb_vote_session_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vote_session_ctrl
//  Description : Table-driven bench for vote_session_ctrl with a plurality
//                stand-in for the majority datapath (TIMEOUT = 8).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vote_session_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  vote_valid;
    logic [14:0] vote_choice;
    logic [2:0]  vm_r;
    logic [2:0]  ballot_a, ballot_b, ballot_c, ballot_d, ballot_e;
    logic        busy, reject, done, timed_out;
    logic [4:0]  voted;
    logic [2:0]  turnout, result;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    vote_session_ctrl #(.TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .vote_valid(vote_valid), .vote_choice(vote_choice), .vm_r(vm_r),
        .ballot_a(ballot_a), .ballot_b(ballot_b), .ballot_c(ballot_c),
        .ballot_d(ballot_d), .ballot_e(ballot_e),
        .busy(busy), .voted(voted), .turnout(turnout), .reject(reject),
        .done(done), .result(result), .timed_out(timed_out)
    );

    function automatic logic [2:0] plural(input logic [14:0] b);
        int n0, n1, n2;
        n0 = 0; n1 = 0; n2 = 0;
        for (int i = 0; i < 5; i++) begin
            if (b[3*i +: 3] == 3'b001) n0++;
            if (b[3*i +: 3] == 3'b010) n1++;
            if (b[3*i +: 3] == 3'b100) n2++;
        end
        if (n0 > n1 && n0 > n2) return 3'b001;
        if (n1 > n0 && n1 > n2) return 3'b010;
        if (n2 > n0 && n2 > n1) return 3'b100;
        return 3'b000;
    endfunction

    // Stand-in for the majority datapath that sits beside the DUT.
    always_comb vm_r = plural({ballot_e, ballot_d, ballot_c, ballot_b, ballot_a});

    function automatic logic [14:0] ch(input logic [2:0] a, b, c, d, e);
        return {e, d, c, b, a};
    endfunction

    typedef struct {
        logic        start;
        logic [4:0]  valid;
        logic [14:0] choice;
        logic [4:0]  voted;
        logic [2:0]  turnout;
        logic        reject;
        logic        busy;
        logic        done;
        logic        tmo;
        logic [2:0]  result;
        logic [14:0] ballots;
    } vec_t;

    vec_t tbl [14];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic chk_all(input string tag, input logic [4:0] e_voted, input logic [2:0] e_turnout,
                           input logic e_reject, input logic e_busy, input logic e_done,
                           input logic e_tmo, input logic [2:0] e_result, input logic [14:0] e_ballots);
        chk({tag, ".voted"},     32'(voted),     32'(e_voted));
        chk({tag, ".turnout"},   32'(turnout),   32'(e_turnout));
        chk({tag, ".reject"},    32'(reject),    32'(e_reject));
        chk({tag, ".busy"},      32'(busy),      32'(e_busy));
        chk({tag, ".done"},      32'(done),      32'(e_done));
        chk({tag, ".timed_out"}, 32'(timed_out), 32'(e_tmo));
        chk({tag, ".result"},    32'(result),    32'(e_result));
        chk({tag, ".ballots"},
            32'({ballot_e, ballot_d, ballot_c, ballot_b, ballot_a}), 32'(e_ballots));
    endtask

    task automatic drive(input logic s, input logic [4:0] v, input logic [14:0] c);
        start       = s;
        vote_valid  = v;
        vote_choice = c;
    endtask

    initial begin
        logic [14:0] b1, b2, bc;
        b1 = ch(3'b100, 3'b010, 3'b001, 3'b100, 3'b100);
        b2 = ch(3'b001, 3'b001, 3'b010, 3'b100, 3'b001);
        bc = ch(3'b000, 3'b000, 3'b100, 3'b000, 3'b000);

        // Staggered session with duplicate/illegal ballots, then a one-cycle full vote.
        tbl[0]  = '{1'b1, 5'b00000, 15'd0, 5'b00000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 15'd0};
        tbl[1]  = '{1'b1, 5'b00010, ch(3'b000, 3'b010, 3'b000, 3'b000, 3'b000),
                    5'b00010, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 15'd0};
        tbl[2]  = '{1'b0, 5'b00010, ch(3'b000, 3'b100, 3'b000, 3'b000, 3'b000),
                    5'b00010, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 15'd0};
        tbl[3]  = '{1'b0, 5'b00001, ch(3'b011, 3'b000, 3'b000, 3'b000, 3'b000),
                    5'b00010, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 15'd0};
        tbl[4]  = '{1'b0, 5'b00001, 15'd0,
                    5'b00010, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 15'd0};
        tbl[5]  = '{1'b0, 5'b00101, ch(3'b100, 3'b000, 3'b001, 3'b000, 3'b000),
                    5'b00111, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 15'd0};
        tbl[6]  = '{1'b0, 5'b01100, ch(3'b000, 3'b000, 3'b010, 3'b100, 3'b000),
                    5'b01111, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 15'd0};
        tbl[7]  = '{1'b0, 5'b10000, ch(3'b000, 3'b000, 3'b000, 3'b000, 3'b100),
                    5'b11111, 3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, b1};
        tbl[8]  = '{1'b0, 5'b00000, 15'd0, 5'b11111, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 3'b100, b1};
        tbl[9]  = '{1'b0, 5'b00000, 15'd0, 5'b11111, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, b1};
        tbl[10] = '{1'b1, 5'b00000, 15'd0, 5'b00000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 15'd0};
        tbl[11] = '{1'b0, 5'b11111, b2,    5'b11111, 3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 3'b100, b2};
        tbl[12] = '{1'b0, 5'b00000, 15'd0, 5'b11111, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001, b2};
        tbl[13] = '{1'b0, 5'b00000, 15'd0, 5'b11111, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, b2};

        rst_n = 1'b0;
        drive(1'b0, 5'b0, 15'd0);
        step();
        step();
        chk_all("reset", 5'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 15'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].start, tbl[i].valid, tbl[i].choice);
            step();
            chk_all($sformatf("row%0d", i), tbl[i].voted, tbl[i].turnout, tbl[i].reject,
                    tbl[i].busy, tbl[i].done, tbl[i].tmo, tbl[i].result, tbl[i].ballots);
        end

        // Timeout with only C voting: close at t+8, done at t+9.
        drive(1'b1, 5'b0, 15'd0);
        step();
        drive(1'b0, 5'b00100, bc);
        step();
        drive(1'b0, 5'b0, 15'd0);
        for (int i = 0; i < 6; i++) step();
        chk_all("tmo_t7", 5'b00100, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 15'd0);
        step();
        chk_all("tmo_t8", 5'b00100, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1, 3'b001, bc);
        step();
        chk_all("tmo_t9", 5'b00100, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1, 3'b100, bc);

        // Fifth vote lands on the timeout edge: not a timeout; start mid-COLLECT ignored.
        drive(1'b1, 5'b0, 15'd0);
        step();
        drive(1'b0, 5'b01111, ch(3'b010, 3'b010, 3'b010, 3'b010, 3'b000));
        step();
        drive(1'b0, 5'b0, 15'd0);
        for (int i = 0; i < 6; i++) begin
            start = (i == 2);
            step();
        end
        chk_all("edge_t7", 5'b01111, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 15'd0);
        drive(1'b0, 5'b10000, ch(3'b000, 3'b000, 3'b000, 3'b000, 3'b010));
        step();
        drive(1'b0, 5'b0, 15'd0);
        chk_all("edge_t8", 5'b11111, 3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 3'b100,
                ch(3'b010, 3'b010, 3'b010, 3'b010, 3'b010));
        step();
        chk_all("edge_t9", 5'b11111, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010,
                ch(3'b010, 3'b010, 3'b010, 3'b010, 3'b010));

        // Reset in the middle of a session with three ballots held.
        drive(1'b1, 5'b0, 15'd0);
        step();
        drive(1'b0, 5'b00111, ch(3'b001, 3'b001, 3'b001, 3'b000, 3'b000));
        step();
        drive(1'b0, 5'b0, 15'd0);
        chk_all("pre_rst", 5'b00111, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 15'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk_all("mid_rst", 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 15'd0);
        step();
        chk_all("idle", 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 15'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
